frame_path_sequencer: RTL and testbench

- Frame-level controller between the downsampler output and the 5x5 window / upsampler path, all in the downsampled-pixel clock domain.
- Tracks pixel row/col position and latches the processing mode (bypass or window) only at frame boundaries.
- Gates pixel valids into the window or bypass path.
- After each frame, drives a flush burst of padding strobes so the window's line buffers drain the frame's last rows before the next frame starts.

---
 rtl/frame_path_sequencer.sv | 132 +++++++++++++
 tb/tb_frame_path_sequencer.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/frame_path_sequencer.sv
// rtl/frame_path_sequencer.sv - frame-level pixel sequencer feeding the 5x5 window or bypass path
module frame_path_sequencer #(
    parameter int WIDTH        = 400,
    parameter int HEIGHT       = 300,
    parameter int FLUSH_CYCLES = 802
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       enable,
    input  logic       mode_req,
    input  logic       valid_in,
    output logic [9:0] rowcount,
    output logic [9:0] colcount,
    output logic       mode_active,
    output logic       win_valid,
    output logic       win_flush,
    output logic       byp_valid,
    output logic       frame_start,
    output logic       frame_end,
    output logic       busy,
    output logic       overrun
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACTIVE = 2'd1,
        S_FLUSH  = 2'd2
    } state_t;

    localparam logic [9:0]  LAST_COL   = 10'(WIDTH - 1);
    localparam logic [9:0]  LAST_ROW   = 10'(HEIGHT - 1);
    localparam logic [15:0] FLUSH_LOAD = 16'(FLUSH_CYCLES - 1);
    localparam bit          HAS_FLUSH  = (FLUSH_CYCLES != 0);

    state_t      state_q;
    logic [9:0]  nrow_q;
    logic [9:0]  ncol_q;
    logic [15:0] flush_q;

    logic [9:0]  pix_row_d;
    logic [9:0]  pix_col_d;
    logic        last_pix_d;
    logic        accept_d;
    logic        mode_sel_d;

    // Position of the pixel being accepted this cycle; a frame always opens at (0,0).
    always_comb begin
        pix_row_d  = (state_q == S_IDLE) ? 10'd0 : nrow_q;
        pix_col_d  = (state_q == S_IDLE) ? 10'd0 : ncol_q;
        last_pix_d = (pix_row_d == LAST_ROW) && (pix_col_d == LAST_COL);
        accept_d   = valid_in && (((state_q == S_IDLE) && enable) || (state_q == S_ACTIVE));
        mode_sel_d = (state_q == S_IDLE) ? mode_req : mode_active;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= S_IDLE;
            nrow_q      <= 10'd0;
            ncol_q      <= 10'd0;
            flush_q     <= 16'd0;
            rowcount    <= 10'd0;
            colcount    <= 10'd0;
            mode_active <= 1'b0;
            win_valid   <= 1'b0;
            win_flush   <= 1'b0;
            byp_valid   <= 1'b0;
            frame_start <= 1'b0;
            frame_end   <= 1'b0;
            busy        <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            win_valid   <= 1'b0;
            win_flush   <= 1'b0;
            byp_valid   <= 1'b0;
            frame_start <= 1'b0;
            frame_end   <= 1'b0;
            case (state_q)
                S_IDLE, S_ACTIVE: begin
                    if (accept_d) begin
                        if (state_q == S_IDLE) begin
                            mode_active <= mode_req;
                            frame_start <= 1'b1;
                        end
                        win_valid <= mode_sel_d;
                        byp_valid <= !mode_sel_d;
                        rowcount  <= pix_row_d;
                        colcount  <= pix_col_d;
                        if (pix_col_d == LAST_COL) begin
                            ncol_q <= 10'd0;
                            nrow_q <= pix_row_d + 10'd1;
                        end else begin
                            ncol_q <= pix_col_d + 10'd1;
                            nrow_q <= pix_row_d;
                        end
                        if (last_pix_d) begin
                            frame_end <= 1'b1;
                            // Only window frames leave rows stranded in the line buffers.
                            if (mode_sel_d && HAS_FLUSH) begin
                                state_q <= S_FLUSH;
                                busy    <= 1'b1;
                                flush_q <= FLUSH_LOAD;
                            end else begin
                                state_q <= S_IDLE;
                                busy    <= 1'b0;
                            end
                        end else begin
                            state_q <= S_ACTIVE;
                            busy    <= 1'b1;
                        end
                    end
                end
                S_FLUSH: begin
                    win_flush <= 1'b1;
                    if (valid_in) begin
                        overrun <= 1'b1;
                    end
                    if (flush_q == 16'd0) begin
                        state_q <= S_IDLE;
                        busy    <= 1'b0;
                    end else begin
                        flush_q <= flush_q - 16'd1;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_frame_path_sequencer.sv
// tb/tb_frame_path_sequencer.sv - vector bench for frame_path_sequencer with a small 8x4 frame
module tb_frame_path_sequencer;

    localparam int W  = 8;
    localparam int H  = 4;
    localparam int FL = 18;

    logic       clock = 1'b0;
    logic       reset, enable, mode_req, valid_in;
    logic [9:0] rowcount, colcount;
    logic       mode_active, win_valid, win_flush, byp_valid;
    logic       frame_start, frame_end, busy, overrun;

    always #5 clock = ~clock;

    frame_path_sequencer #(.WIDTH(W), .HEIGHT(H), .FLUSH_CYCLES(FL)) dut (
        .clock(clock), .reset(reset), .enable(enable), .mode_req(mode_req),
        .valid_in(valid_in), .rowcount(rowcount), .colcount(colcount),
        .mode_active(mode_active), .win_valid(win_valid), .win_flush(win_flush),
        .byp_valid(byp_valid), .frame_start(frame_start), .frame_end(frame_end),
        .busy(busy), .overrun(overrun)
    );

    typedef struct {
        logic        rst, en, md, vin;
        logic [27:0] exp;
    } vec_t;

    vec_t tbl[$];
    int   vectors = 0;
    int   errors  = 0;

    // Reference state: frame progress tracked as a linear pixel index.
    int         m_st = 0, m_k = 0, m_fl = 0;
    logic       m_md = 1'b0, m_ovr = 1'b0;
    logic [9:0] m_row = 10'd0, m_col = 10'd0;

    task automatic pixel(output logic wv, output logic bv, output logic fe);
        wv = 1'b0; bv = 1'b0; fe = 1'b0;
        m_row = 10'(m_k / W);
        m_col = 10'(m_k % W);
        if (m_md) wv = 1'b1; else bv = 1'b1;
        if (m_k == W * H - 1) begin
            fe = 1'b1;
            if (m_md && FL > 0) begin m_st = 2; m_fl = FL; end
            else m_st = 0;
        end else begin
            m_st = 1;
        end
        m_k++;
    endtask

    task automatic add(input logic rst, input logic en, input logic md, input logic vin);
        vec_t v;
        logic wv, bv, wf, fs, fe;
        wv = 1'b0; bv = 1'b0; wf = 1'b0; fs = 1'b0; fe = 1'b0;
        if (rst) begin
            m_st = 0; m_k = 0; m_fl = 0; m_md = 1'b0; m_ovr = 1'b0;
            m_row = 10'd0; m_col = 10'd0;
        end else begin
            case (m_st)
                0: if (en && vin) begin m_md = md; m_k = 0; fs = 1'b1; pixel(wv, bv, fe); end
                1: if (vin) pixel(wv, bv, fe);
                default: begin
                    wf = 1'b1;
                    if (vin) m_ovr = 1'b1;
                    m_fl--;
                    if (m_fl == 0) m_st = 0;
                end
            endcase
        end
        v.rst = rst; v.en = en; v.md = md; v.vin = vin;
        v.exp = {m_row, m_col, m_md, wv, wf, bv, fs, fe, (m_st != 0), m_ovr};
        tbl.push_back(v);
    endtask

    task automatic rep(input int n, input logic rst, input logic en, input logic md, input logic vin);
        for (int i = 0; i < n; i++) add(rst, en, md, vin);
    endtask

    task automatic pixels(input int n, input logic md, input int gap, input logic en);
        for (int i = 0; i < n; i++) begin
            add(1'b0, en, md, 1'b1);
            rep(gap, 1'b0, en, md, 1'b0);
        end
    endtask

    task automatic chk(input string name, input int got, input int exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    initial begin
        int n_wv, n_bv, n_wf, fe_cyc, fs2_cyc, fe_row, fe_col;
        logic [27:0] act;
        reset = 1'b1; enable = 1'b0; mode_req = 1'b0; valid_in = 1'b0;

        rep(2, 1'b1, 1'b0, 1'b0, 1'b0);
        rep(3, 1'b0, 1'b0, 1'b1, 1'b1);           // dropped while disabled
        pixels(32, 1'b1, 0, 1'b1);                 // window frame
        rep(20, 1'b0, 1'b1, 1'b1, 1'b0);           // flush + idle
        pixels(64, 1'b0, 0, 1'b1);                 // two back-to-back bypass frames
        rep(2, 1'b0, 1'b1, 1'b0, 1'b0);
        pixels(10, 1'b1, 0, 1'b1);                 // mode toggled at pixel 10
        pixels(22, 1'b0, 0, 1'b1);
        rep(18, 1'b0, 1'b1, 1'b0, 1'b0);
        pixels(32, 1'b0, 0, 1'b1);
        pixels(1, 1'b0, 3, 1'b1);                  // gapped frame, enable dropped mid-frame
        pixels(31, 1'b0, 3, 1'b0);
        rep(2, 1'b0, 1'b0, 1'b0, 1'b0);
        pixels(32, 1'b1, 0, 1'b1);                 // overrun at flush cycle 5
        rep(5, 1'b0, 1'b1, 1'b1, 1'b0);
        add(1'b0, 1'b1, 1'b1, 1'b1);
        rep(14, 1'b0, 1'b1, 1'b1, 1'b0);
        pixels(19, 1'b1, 0, 1'b1);                 // reset at pixel (2,3)
        add(1'b1, 1'b1, 1'b1, 1'b1);
        rep(2, 1'b0, 1'b0, 1'b0, 1'b0);
        pixels(32, 1'b1, 0, 1'b1);                 // reset at flush cycle 9
        rep(9, 1'b0, 1'b1, 1'b1, 1'b0);
        add(1'b1, 1'b1, 1'b1, 1'b0);
        rep(2, 1'b0, 1'b0, 1'b0, 1'b0);
        pixels(3, 1'b1, 0, 1'b1);
        add(1'b1, 1'b0, 1'b0, 1'b0);

        foreach (tbl[i]) begin
            reset = tbl[i].rst; enable = tbl[i].en; mode_req = tbl[i].md; valid_in = tbl[i].vin;
            @(posedge clock); #1;
            act = {rowcount, colcount, mode_active, win_valid, win_flush, byp_valid,
                   frame_start, frame_end, busy, overrun};
            vectors++;
            if (act !== tbl[i].exp) begin
                errors++;
                $display("FAIL vec %0d: got %h expected %h", i, act, tbl[i].exp);
            end
        end

        // Window frame: strobe totals, frame_end position and flush length.
        reset = 1'b0; enable = 1'b1; mode_req = 1'b1; valid_in = 1'b1;
        n_wv = 0; n_bv = 0; n_wf = 0; fe_row = -1; fe_col = -1;
        for (int c = 0; c < 32; c++) begin
            @(posedge clock); #1;
            if (c == 0) chk("first_frame_start", int'(frame_start), 1);
            n_wv += int'(win_valid); n_bv += int'(byp_valid);
            if (frame_end) begin fe_row = int'(rowcount); fe_col = int'(colcount); end
        end
        valid_in = 1'b0;
        for (int c = 0; c < 30; c++) begin
            @(posedge clock); #1;
            n_wf += int'(win_flush);
        end
        chk("win_valid_count", n_wv, 32);
        chk("byp_valid_count", n_bv, 0);
        chk("frame_end_row", fe_row, 3);
        chk("frame_end_col", fe_col, 7);
        chk("flush_count", n_wf, 18);
        chk("busy_after_flush", int'(busy), 0);

        // Bypass frames back to back: no dead cycle, no flush.
        mode_req = 1'b0; valid_in = 1'b1;
        n_bv = 0; n_wf = 0; fe_cyc = -1; fs2_cyc = -1;
        for (int c = 0; c < 64; c++) begin
            @(posedge clock); #1;
            n_bv += int'(byp_valid); n_wf += int'(win_flush);
            if (frame_end && fe_cyc < 0) fe_cyc = c;
            if (frame_start && c > 0) fs2_cyc = c;
        end
        valid_in = 1'b0;
        @(posedge clock); #1;
        chk("byp_count_two_frames", n_bv, 64);
        chk("bypass_no_flush", n_wf, 0);
        chk("first_frame_end_cycle", fe_cyc, 31);
        chk("second_frame_start_cycle", fs2_cyc, 32);
        chk("idle_after_bypass", int'(busy), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
